// File: rtl/csel_subtractor_pipe.sv
// csel_subtractor_pipe: two-stage carry-select A-B with borrow and valid/ready; define CSEL_SUB_OVF_EN to add the signed overflow output ovf
module csel_subtractor_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = WIDTH / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   DIFF
`ifdef CSEL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int HI = WIDTH - SPLIT;
  logic [SPLIT:0]   lo_sum;
  logic [HI:0]      hi_sum0, hi_sum1;
  logic             s2_free, in_xfer, s1_adv;
  logic             s1_valid, s1_borrow_lo, s1_bo0, s1_bo1;
  logic [SPLIT-1:0] s1_d_lo;
  logic [HI-1:0]    s1_u0, s1_u1;
  logic [WIDTH:0]   sel_diff;
`ifdef CSEL_SUB_OVF_EN
  logic             s1_a_msb, s1_b_msb;
`endif
  // a stalled output frees the stage only when it is being taken; in_ready follows out_ready combinationally
  always_comb begin
    s2_free  = ~out_valid | out_ready;
    in_ready = ~s1_valid | s2_free;
    in_xfer  = in_valid & in_ready;
    s1_adv   = s1_valid & s2_free;
  end
  // low segment and both upper candidates (borrow-in 0 and 1) are computed unconditionally
  always_comb begin
    lo_sum  = {1'b0, A[SPLIT-1:0]} + {1'b0, ~B[SPLIT-1:0]} + (SPLIT+1)'(1);
    hi_sum0 = {1'b0, A[WIDTH-1:SPLIT]} + {1'b0, ~B[WIDTH-1:SPLIT]} + (HI+1)'(1);
    hi_sum1 = {1'b0, A[WIDTH-1:SPLIT]} + {1'b0, ~B[WIDTH-1:SPLIT]};
  end
  // the low-segment borrow picks which upper candidate becomes the result
  always_comb begin
    sel_diff = s1_borrow_lo ? {s1_bo1, s1_u1, s1_d_lo} : {s1_bo0, s1_u0, s1_d_lo};
  end
  // stage 1 captures on an input transfer and empties when it advances without a refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_d_lo      <= '0;
      s1_borrow_lo <= 1'b0;
      s1_u0        <= '0;
      s1_u1        <= '0;
      s1_bo0       <= 1'b0;
      s1_bo1       <= 1'b0;
    end else begin
      s1_valid <= in_xfer ? 1'b1 : (s1_adv ? 1'b0 : s1_valid);
      if (in_xfer) begin
        s1_d_lo      <= lo_sum[SPLIT-1:0];
        s1_borrow_lo <= ~lo_sum[SPLIT];
        s1_u0        <= hi_sum0[HI-1:0];
        s1_u1        <= hi_sum1[HI-1:0];
        s1_bo0       <= ~hi_sum0[HI];
        s1_bo1       <= ~hi_sum1[HI];
      end
    end
  end
  // stage 2 refills whenever it is free and holds its result under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DIFF      <= '0;
    end else begin
      if (s2_free) out_valid <= s1_valid;
      if (s1_adv) DIFF <= sel_diff;
    end
  end
`ifdef CSEL_SUB_OVF_EN
  // operand sign bits ride along stage 1 so the overflow flag can be formed from the selected result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (in_xfer) begin
      s1_a_msb <= A[WIDTH-1];
      s1_b_msb <= B[WIDTH-1];
    end
  end
  // overflow is registered alongside DIFF with the same update condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (s1_adv) ovf <= (s1_a_msb ^ s1_b_msb) & (sel_diff[WIDTH-1] ^ s1_a_msb);
  end
`endif
endmodule

// File: tb/tb_csel_subtractor_pipe.sv
// tb_csel_subtractor_pipe: directed and random checks of csel_subtractor_pipe against an arithmetic scoreboard
module tb_csel_subtractor_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [32:0] DIFF;
`ifdef CSEL_SUB_OVF_EN
  logic        ovf;
`endif
  int          n_chk = 0;
  int          n_fail = 0;
  logic [33:0] q[$];
  logic        acc;

  always #5 clk = ~clk;

  csel_subtractor_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .DIFF(DIFF)
`ifdef CSEL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    longint      s;
    d = {1'b0, a} - {1'b0, b};
    s = longint'($signed(a)) - longint'($signed(b));
    return {(s > 64'sd2147483647) || (s < -64'sd2147483648), d};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ordy, output logic accepted);
    logic [33:0] e;
    in_valid = v; A = a; B = b; out_ready = ordy;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 33'(out_valid), 33'(0));
      else begin
        e = q.pop_front();
        chk("diff", DIFF, e[32:0]);
`ifdef CSEL_SUB_OVF_EN
        chk("ovf", 33'(ovf), 33'(e[33]));
`endif
      end
    end
    if (accepted) q.push_back(model(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ordy);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) cycle(1'b1, a, b, ordy, ok);
    chk("send_accept", 33'(ok), 33'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic dummy;
    for (int t = 0; t < 20 && q.size() > 0; t++) cycle(1'b0, '0, '0, 1'b1, dummy);
    chk("drain_empty", 33'(q.size()), 33'(0));
  endtask

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    logic ok;
    cycle(1'b1, a, b, 1'b1, ok);
    chk({tag, "_accept"}, 33'(ok), 33'(1));
    chk({tag, "_lat1_valid"}, 33'(out_valid), 33'(0));
    cycle(1'b0, '0, '0, 1'b1, ok);
    chk({tag, "_lat2_valid"}, 33'(out_valid), 33'(1));
    chk(tag, DIFF, exp);
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 33'(out_valid), 33'(0));
    chk("rst_diff", DIFF, 33'(0));
    chk("rst_in_ready", 33'(in_ready), 33'(1));
    single("basic_5_3", 32'd5, 32'd3, 33'h0_0000_0002);
    single("basic_3_5", 32'd3, 32'd5, 33'h1_FFFF_FFFE);
    single("split_borrow", 32'h0001_0000, 32'h0000_0001, 33'h0_0000_FFFF);
    single("zero_minus_max", 32'h0, 32'hFFFF_FFFF, 33'h1_0000_0001);
    r = $urandom;
    single("a_eq_b", r, r, 33'h0);
    r = $urandom;
    single("b_zero", r, 32'h0, {1'b0, r});
    single("ovf_min", 32'h8000_0000, 32'h1, 33'h0_7FFF_FFFF);
`ifdef CSEL_SUB_OVF_EN
    chk("ovf_min_flag", 33'(ovf), 33'(1));
`endif
    single("ovf_none", 32'd5, 32'd3, 33'h2);
`ifdef CSEL_SUB_OVF_EN
    chk("ovf_none_flag", 33'(ovf), 33'(0));
`endif
    cycle(1'b1, 32'd10, 32'd1, 1'b0, acc);
    chk("bp_acc1", 33'(acc), 33'(1));
    cycle(1'b1, 32'd20, 32'd2, 1'b0, acc);
    chk("bp_acc2", 33'(acc), 33'(1));
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'd30, 32'd3, 1'b0, acc);
      chk("bp_reject", 33'(acc), 33'(0));
      chk("bp_in_ready", 33'(in_ready), 33'(0));
      chk("bp_out_valid", 33'(out_valid), 33'(1));
      chk("bp_hold_diff", DIFF, 33'd9);
    end
    send(32'd30, 32'd3, 1'b1);
    send(32'd40, 32'd4, 1'b1);
    drain();
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, $urandom, (i % 10 == 3) ? A : $urandom, 1'b1, acc);
      chk("tp_accept", 33'(acc), 33'(1));
      if (i >= 1) chk("tp_out_valid", 33'(out_valid), 33'(1));
    end
    drain();
    cycle(1'b1, 32'd7, 32'd1, 1'b0, acc);
    cycle(1'b1, 32'd8, 32'd2, 1'b0, acc);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 33'(out_valid), 33'(0));
    chk("midrst_diff", DIFF, 33'(0));
    chk("midrst_in_ready", 33'(in_ready), 33'(1));
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, '0, '0, 1'b1, acc);
      chk("postrst_no_output", 33'(out_valid), 33'(0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csel_subtractor_pipe.md
Name: csel_subtractor_pipe

Overview:
- Pipelined carry-select subtractor; the inverse arithmetic counterpart of the team's combinational carry-select adder.
- Computes A − B for unsigned WIDTH-bit operands and reports the borrow.
- Two register stages with valid/ready handshake on both sides.
- Sits in the datapath test harness alongside the adder variants so add and subtract results can be checked against each other.

Parameters:
WIDTH, 32, operand width; must be even and ≥ 4
SPLIT, WIDTH/2, width of the low segment; upper segment is WIDTH−SPLIT

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
A  input  WIDTH  minuend, unsigned
B  input  WIDTH  subtrahend, unsigned
out_valid  output  1  DIFF valid
out_ready  input  1  downstream accepts DIFF this cycle
DIFF  output  WIDTH+1  DIFF[WIDTH-1:0] = (A−B) mod 2^WIDTH; DIFF[WIDTH] = borrow (1 iff A < B)

Behaviour:
- Reset (async assert, deassert is synchronous to clk):
  - s1_valid = 0, out_valid = 0, DIFF = 0.
  - in_ready = 1 in the first cycle after reset.
  - All in-flight data is discarded; reset mid-operation produces no output.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - A and B are sampled only on an input transfer.
- Stage 1 (registered at the input transfer):
  - Low segment: {c_lo, d_lo} = A[SPLIT-1:0] + ~B[SPLIT-1:0] + 1; store d_lo and borrow_lo = ~c_lo.
  - Upper candidates: {c0, u0} = A_hi + ~B_hi + 1 (borrow-in 0) and {c1, u1} = A_hi + ~B_hi (borrow-in 1).
  - Store u0, u1, bo0 = ~c0, bo1 = ~c1.
  - Both candidates are computed unconditionally.
- Stage 2 (registered):
  - Select with borrow_lo: DIFF = borrow_lo ? {bo1, u1, d_lo} : {bo0, u0, d_lo}.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput: 1 result per cycle.
- Pipeline control:
  - s2_free = ~out_valid | out_ready.
  - Stage 1 advances to stage 2 when s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Backpressure:
  - While out_valid & ~out_ready, DIFF and out_valid hold stable.
  - Stage 1 holds its contents. If stage 1 is occupied, in_ready = 0.
  - No result is dropped or duplicated.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both honoured; the pipeline refills without a bubble.
  - out_valid deasserts only after a transfer with no new stage-1 data available.
- Boundaries:
  - A = B gives DIFF = 0, borrow 0.
  - B = 0 gives DIFF = {0, A}.
  - A = 0, B = 2^WIDTH−1 gives DIFF = {1, 0…01}.
- Ordering: results leave in input order. Capacity is 2 operations.

Optional Feature:
- Macro: CSEL_SUB_OVF_EN.
- When defined:
  - Extra output port `ovf output 1`: the signed two's-complement overflow flag, (A[W-1] ≠ B[W-1]) & (DIFF[W-1] ≠ A[W-1]).
  - Operand MSBs are carried through stage 1; ovf is registered alongside DIFF with identical valid, hold and reset behaviour (reset 0).
- When undefined: the port does not exist and no extra flops are inferred; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: assert rst_n = 0 while two operations are in flight, then release.
  - Required: out_valid = 0, DIFF = 0, in_ready = 1; neither result ever appears.
- Basic:
  - Stimulus: A = 5, B = 3, out_ready = 1.
  - Required: 2 cycles later out_valid = 1, DIFF = 0x0_0000_0002.
  - Stimulus: A = 3, B = 5.
  - Required: DIFF = 0x1_FFFF_FFFE.
- Split borrow:
  - Stimulus: A = 0x0001_0000, B = 0x0000_0001.
  - Required: DIFF = 0x0_0000_FFFF (borrow_lo selects the u1 path).
  - Stimulus: A = 0x0000_0000, B = 0xFFFF_FFFF.
  - Required: DIFF = 0x1_0000_0001.
- Backpressure:
  - Stimulus: stream 4 operations (10−1, 20−2, 30−3, 40−4) with out_ready = 0 for 5 cycles.
  - Required: in_ready drops after 2 accepts; DIFF holds 9 stable; on release, outputs 9, 18, 27, 36 in order, no loss.
- Throughput:
  - Stimulus: 100 random back-to-back pairs with out_ready = 1.
  - Required: one result per cycle after 2-cycle fill; each equals the {0,A} − {0,B} model.
- Overflow (CSEL_SUB_OVF_EN defined):
  - Stimulus: A = 0x8000_0000, B = 1.
  - Required: DIFF = 0x0_7FFF_FFFF, ovf = 1.
  - Stimulus: A = 5, B = 3.
  - Required: ovf = 0.
